// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio sample type, midscale constant and duty helpers
package audio_pkg;

  localparam int SAMPLE_W = 8;
  localparam logic [SAMPLE_W-1:0] MIDSCALE = 8'd128;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Arithmetic shift keeps the sign, so small negative samples settle at -1, not 0.
  function automatic sample_t attenuate(input sample_t s, input logic [2:0] shift);
    return s >>> shift;
  endfunction

  // Two's complement to offset binary: flipping the MSB is the same as adding midscale.
  function automatic logic [SAMPLE_W-1:0] to_offset_binary(input sample_t s);
    return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// rtl/sample_tick_gen.sv - free-running sample-rate strobe, one cycle every TICK_DIV clocks while enabled
module sample_tick_gen #(
  parameter int TICK_DIV = 2000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Gated so the strobe is silent in any reset or idle cycle, whatever the counter holds.
  assign tick = !rst && en && (cnt == LAST);

endmodule

// File: rtl/pwm_audio_out.sv
// rtl/pwm_audio_out.sv - sample capture, volume/mute, and glitch-free 8-bit PWM audio driver
module pwm_audio_out
  import audio_pkg::*;
#(
  parameter int TICK_DIV = 2000,
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic [2:0]          volume,
  input  logic                mute,
  output logic                sample_tick,
  output logic                aud_pwm,
  output logic                aud_sd
);

  logic                capture_q;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_pending;
  logic [PWM_BITS-1:0] duty_active;
  sample_t             scaled;

  assign scaled = attenuate(sample_t'(sample_in), volume);

  sample_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .tick(sample_tick)
  );

  // The reader updates on the edge ending the tick cycle, so sample one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      capture_q    <= 1'b0;
      duty_pending <= MIDSCALE;
    end else begin
      capture_q <= sample_tick;
      if (capture_q) begin
        duty_pending <= mute ? MIDSCALE : to_offset_binary(scaled);
      end
    end
  end

  // duty_active only changes at the frame boundary so a frame never mixes two duties.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt     <= '0;
      duty_active <= MIDSCALE;
      aud_pwm     <= 1'b0;
      aud_sd      <= 1'b0;
    end else begin
      aud_sd  <= en;
      aud_pwm <= en && (pwm_cnt < duty_active);
      if (!en) begin
        pwm_cnt <= '0;
      end else begin
        pwm_cnt <= pwm_cnt + 1'b1;
        if (pwm_cnt == '1) begin
          duty_active <= duty_pending;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_audio_out.sv
// tb/tb_pwm_audio_out.sv - directed self-checking bench for pwm_audio_out
module tb_pwm_audio_out;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] sample_in;
  logic [7:0] sample_drv;
  logic [2:0] volume;
  logic       mute;
  logic       sample_tick;
  logic       aud_pwm;
  logic       aud_sd;

  logic       en_b;
  logic [7:0] sample_b;
  logic [2:0] vol_b;
  logic       mute_b;
  logic       tick_b;
  logic       pwm_b;
  logic       sd_b;

  logic             use_reader;
  logic             rd_clr;
  int               rd_idx;
  logic signed [7:0] sine [0:251];

  int errors;
  int checks;

  pwm_audio_out #(.TICK_DIV(20)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sample_in  (sample_in),
    .volume     (volume),
    .mute       (mute),
    .sample_tick(sample_tick),
    .aud_pwm    (aud_pwm),
    .aud_sd     (aud_sd)
  );

  // Second instance whose tick phase lands captures on PWM counts 37 and 255.
  pwm_audio_out #(.TICK_DIV(37)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .en         (en_b),
    .sample_in  (sample_b),
    .volume     (vol_b),
    .mute       (mute_b),
    .sample_tick(tick_b),
    .aud_pwm    (pwm_b),
    .aud_sd     (sd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream sine reader: index advances on the edge that ends the tick cycle.
  always @(posedge clk) begin
    if (rd_clr) rd_idx <= 0;
    else if (sample_tick) rd_idx <= (rd_idx == 251) ? 0 : rd_idx + 1;
  end

  assign sample_in = use_reader ? sine[rd_idx] : sample_drv;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Restart the counters with new inputs and count aud_pwm highs over frame 1.
  task automatic measure(input int s, input int vol, input int m, output int highs);
    en = 1'b0;
    step();
    step();
    sample_drv = s[7:0];
    volume     = vol[2:0];
    mute       = m[0];
    en         = 1'b1;
    repeat (256) step();
    highs = 0;
    repeat (256) begin
      step();
      highs += int'(aud_pwm);
    end
  endtask

  task automatic test_reset();
    int ticks;
    int highs;
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) step();
    checks++;
    if (sample_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", sample_tick); end
    checks++;
    if (aud_pwm !== 1'b0) begin errors++; $display("FAIL reset_pwm: got %b expected 0", aud_pwm); end
    checks++;
    if (aud_sd !== 1'b0) begin errors++; $display("FAIL reset_sd: got %b expected 0", aud_sd); end
    checks++;
    if (pwm_b !== 1'b0 || sd_b !== 1'b0) begin errors++; $display("FAIL reset_b: got pwm=%b sd=%b expected 0 0", pwm_b, sd_b); end
    rst = 1'b0;
    en  = 1'b0;
    ticks = 0;
    highs = 0;
    repeat (500) begin
      step();
      ticks += int'(sample_tick);
      highs += int'(aud_pwm);
    end
    checks++;
    if (ticks !== 0) begin errors++; $display("FAIL idle_ticks: got %0d expected 0", ticks); end
    checks++;
    if (highs !== 0) begin errors++; $display("FAIL idle_pwm: got %0d expected 0", highs); end
  endtask

  task automatic test_tick_cadence();
    logic exp;
    en = 1'b1;
    for (int n = 1; n <= 65; n++) begin
      exp = (n % 20 == 0);
      checks++;
      if (sample_tick !== exp) begin errors++; $display("FAIL tick_cycle%0d: got %b expected %b", n, sample_tick, exp); end
      step();
    end
    checks++;
    if (aud_sd !== 1'b1) begin errors++; $display("FAIL sd_on: got %b expected 1", aud_sd); end
    en = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      checks++;
      if (sample_tick !== 1'b0) begin errors++; $display("FAIL tick_disabled%0d: got %b expected 0", i, sample_tick); end
    end
    checks++;
    if (aud_sd !== 1'b0) begin errors++; $display("FAIL sd_off: got %b expected 0", aud_sd); end
    en = 1'b1;
    for (int n = 1; n <= 41; n++) begin
      exp = (n % 20 == 0);
      checks++;
      if (sample_tick !== exp) begin errors++; $display("FAIL tick_reen_cycle%0d: got %b expected %b", n, sample_tick, exp); end
      step();
    end
  endtask

  task automatic test_duty_mapping();
    int vs[3] = '{0, 127, -128};
    int ve[3] = '{128, 255, 0};
    int h;
    for (int i = 0; i < 3; i++) begin
      measure(vs[i], 0, 0, h);
      checks++;
      if (h !== ve[i]) begin errors++; $display("FAIL duty_map s=%0d: got %0d highs expected %0d", vs[i], h, ve[i]); end
    end
  endtask

  task automatic test_volume_mute();
    int vs[6] = '{-128, 100, -1, 127, 64, -1};
    int vv[6] = '{2, 3, 7, 0, 1, 0};
    int vm[6] = '{0, 0, 0, 1, 0, 0};
    int ve[6] = '{96, 140, 127, 128, 160, 127};
    int h;
    for (int i = 0; i < 6; i++) begin
      measure(vs[i], vv[i], vm[i], h);
      checks++;
      if (h !== ve[i]) begin
        errors++;
        $display("FAIL vol_mute s=%0d v=%0d m=%0d: got %0d highs expected %0d", vs[i], vv[i], vm[i], h, ve[i]);
      end
    end
  endtask

  task automatic test_enable();
    int h;
    measure(127, 0, 0, h);
    step();
    checks++;
    if (aud_pwm !== 1'b1) begin errors++; $display("FAIL en_pre_high: got %b expected 1", aud_pwm); end
    en = 1'b0;
    step();
    checks++;
    if (aud_pwm !== 1'b0 || aud_sd !== 1'b0) begin errors++; $display("FAIL en_off: got pwm=%b sd=%b expected 0 0", aud_pwm, aud_sd); end
    repeat (10) step();
    sample_drv = 8'h80;
    en = 1'b1;
    h = 0;
    repeat (256) begin step(); h += int'(aud_pwm); end
    checks++;
    if (h !== 255) begin errors++; $display("FAIL en_held_duty: got %0d highs expected 255", h); end
    h = 0;
    repeat (256) begin step(); h += int'(aud_pwm); end
    checks++;
    if (h !== 0) begin errors++; $display("FAIL en_next_duty: got %0d highs expected 0", h); end
  endtask

  task automatic test_frame_boundary();
    int hi[14];
    int fexp[14];
    for (int f = 0; f < 14; f++) hi[f] = 0;
    fexp[0] = 128; fexp[1] = 192; fexp[11] = 192; fexp[12] = 192; fexp[13] = 64;
    sample_b = 8'h40;
    en_b = 1'b1;
    for (int n = 1; n <= 3585; n++) begin
      if (n >= 2) hi[(n - 2) / 256] += int'(pwm_b);
      if (n == 130) begin
        checks++;
        if (pwm_b !== 1'b0) begin errors++; $display("FAIL midframe_keep: got %b expected 0", pwm_b); end
      end
      if (n == 258) begin
        checks++;
        if (pwm_b !== 1'b1) begin errors++; $display("FAIL newframe_start: got %b expected 1", pwm_b); end
      end
      if (n == 3040) sample_b = 8'hC0;
      step();
    end
    en_b = 1'b0;
    for (int f = 0; f < 14; f++) begin
      if (f <= 1 || f >= 11) begin
        checks++;
        if (hi[f] !== fexp[f]) begin errors++; $display("FAIL boundary_frame%0d: got %0d highs expected %0d", f, hi[f], fexp[f]); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int h;
    en = 1'b0;
    step();
    step();
    sample_drv = 8'd127;
    volume = 3'd0;
    mute = 1'b0;
    en = 1'b1;
    repeat (356) step();
    checks++;
    if (aud_pwm !== 1'b1) begin errors++; $display("FAIL rst_pre_high: got %b expected 1", aud_pwm); end
    rst = 1'b1;
    step();
    checks++;
    if (aud_pwm !== 1'b0 || aud_sd !== 1'b0 || sample_tick !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got pwm=%b sd=%b tick=%b expected 0 0 0", aud_pwm, aud_sd, sample_tick);
    end
    rst = 1'b0;
    h = 0;
    repeat (256) begin step(); h += int'(aud_pwm); end
    checks++;
    if (h !== 128) begin errors++; $display("FAIL rst_duty_mid: got %0d highs expected 128", h); end
    h = 0;
    repeat (256) begin step(); h += int'(aud_pwm); end
    checks++;
    if (h !== 255) begin errors++; $display("FAIL rst_duty_after: got %0d highs expected 255", h); end
  endtask

  task automatic test_sine_end_to_end();
    int acc;
    int f;
    int k;
    int sv;
    int exp;
    en = 1'b0;
    volume = 3'd0;
    mute = 1'b0;
    rd_clr = 1'b1;
    step();
    step();
    rd_clr = 1'b0;
    use_reader = 1'b1;
    en = 1'b1;
    acc = 0;
    for (int n = 1; n <= 5633; n++) begin
      if (n >= 258) begin
        acc += int'(aud_pwm);
        if ((n - 2) % 256 == 255) begin
          f = (n - 2) / 256;
          k = (256 * f - 2) / 20;
          sv = sine[k % 252];
          exp = sv + 128;
          checks++;
          if (acc !== exp) begin errors++; $display("FAIL sine_frame%0d: got %0d highs expected %0d", f, acc, exp); end
          acc = 0;
        end
      end
      step();
    end
    use_reader = 1'b0;
    en = 1'b0;
  endtask

  initial begin
    int t;
    errors = 0;
    checks = 0;
    for (int i = 0; i < 252; i++) begin
      t = $rtoi($floor(127.0 * $sin(2.0 * 3.14159265358979 * i / 252.0) + 0.5));
      sine[i] = t[7:0];
    end
    rst = 1'b1;
    en = 1'b0;
    sample_drv = 8'd0;
    volume = 3'd0;
    mute = 1'b0;
    en_b = 1'b0;
    sample_b = 8'd0;
    vol_b = 3'd0;
    mute_b = 1'b0;
    use_reader = 1'b0;
    rd_clr = 1'b1;
    rd_idx = 0;
    test_reset();
    rd_clr = 1'b0;
    test_tick_cadence();
    test_duty_mapping();
    test_volume_mute();
    test_enable();
    test_frame_boundary();
    test_reset_midframe();
    test_sine_end_to_end();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
